inst_encoder: RTL



---
 rtl/inst_encoder_if.sv | 34 +++
 rtl/inst_encoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// Instruction-field handshake bundle feeding inst_encoder.
// master: field producer (in_valid, fields, in_last); slave: encoder (in_ready).
interface inst_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rs;
  logic [1:0] in_rt;
  logic [1:0] in_rd;
  logic [7:0] in_imm;
  logic       in_last;

  modport master (
    output in_valid,
    output in_op,
    output in_rs,
    output in_rt,
    output in_rd,
    output in_imm,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rs,
    input  in_rt,
    input  in_rd,
    input  in_imm,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs instruction fields into 16-bit words and streams them into imem.
// Ports: clk, rst_n, start/base_addr, in_bus (fields), imem_stall,
// imem_we/addr/wdata, busy, done, err_illegal, word_count.
// INST_ENCODER_ILLEGAL_NOP_EN: illegal ops enqueue 16'hF000 instead of
// being dropped.
module inst_encoder (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    base_addr,
  inst_encoder_if.slave in_bus,
  input  logic          imem_stall,
  output logic          imem_we,
  output logic [7:0]    imem_addr,
  output logic [15:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_illegal,
  output logic [8:0]    word_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0] fifo_q [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  logic [7:0]  addr_q;
  logic [8:0]  wcnt_q;
  logic        err_q;

  logic        is_r;
  logic        is_i;
  logic        is_ri;
  logic        is_bad;
  logic [15:0] word;

  logic        accept;
  logic        push;
  logic        pop;
  logic        start_go;
  logic        ready;

  // ---------------- field packing ----------------
  always_comb begin
    is_r   = in_bus.in_op inside {4'd2, 4'd4, 4'd5, 4'd7, 4'd13};
    is_i   = in_bus.in_op inside {4'd0, 4'd1, 4'd11, 4'd12};
    is_ri  = in_bus.in_op inside {4'd3, 4'd6, 4'd8, 4'd9, 4'd10};
    is_bad = in_bus.in_op inside {4'd14, 4'd15};
  end

  always_comb begin
    word = 16'hF000;
    unique case (1'b1)
      is_r: word = {in_bus.in_op, in_bus.in_rs,
                    in_bus.in_rt, in_bus.in_rd, 6'b0};
      is_i: word = {in_bus.in_op, in_bus.in_rs,
                    in_bus.in_rt, in_bus.in_imm};
      is_ri: word = {in_bus.in_op, in_bus.in_rs,
                     in_bus.in_rd, in_bus.in_imm};
      default: word = 16'hF000;
    endcase
  end

  // ---------------- handshake ----------------
  assign full   = (count == 3'd4);
  assign empty  = (count == 3'd0);
  assign accept = in_bus.in_valid && ready;

`ifdef INST_ENCODER_ILLEGAL_NOP_EN
  assign push = accept;
`else
  assign push = accept && !is_bad;
`endif

  assign pop      = !empty && !imem_stall;
  assign start_go = (state == IDLE) && start;

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- address / status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 8'd0;
      wcnt_q <= 9'd0;
      err_q  <= 1'b0;
    end else if (start_go) begin
      addr_q <= base_addr;
      wcnt_q <= 9'd0;
      err_q  <= 1'b0;
    end else begin
      // 8-bit address wraps 0xFF -> 0x00 naturally.
      if (pop) addr_q <= addr_q + 8'd1;
      if (pop) wcnt_q <= wcnt_q + 9'd1;
      if (accept && is_bad) err_q <= 1'b1;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (accept && in_bus.in_last) state_nx = DRAIN;
      DRAIN: if (empty) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    unique case (state)
      IDLE:  ;
      LOAD: begin
        busy  = 1'b1;
        ready = !full;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign in_bus.in_ready = ready;
  assign imem_we         = pop;
  assign imem_addr       = addr_q;
  // Gated so the data bus reads zero whenever nothing is written.
  assign imem_wdata      = pop ? fifo_q[rd_ptr] : 16'h0000;
  assign err_illegal     = err_q;
  assign word_count      = wcnt_q;

endmodule
